hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage lw/sw/beq/R-type pipeline.
- Drives the enable and flush (bubble-insert) controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken-beq flushes (branch resolved in MEM) and multi-cycle data-memory freezes.
- Generates the EX-stage operand forwarding selects.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/fwd_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // A load in MEM has no data yet, so only ALU results forward from MEM.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic [4:0] mem_rw,
        input logic       mem_regwr,
        input logic       mem_load,
        input logic [4:0] wr_rw,
        input logic       wr_regwr
    );
        if (mem_regwr && !mem_load && (mem_rw != 5'd0) && (mem_rw == src))
            return FWD_MEM;
        else if (wr_regwr && (wr_rw != 5'd0) && (wr_rw == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - EX-stage operand forwarding select generation
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] mem_rw_i,
    input  logic       mem_regwr_i,
    input  logic       mem_memtoreg_i,
    input  logic [4:0] wr_rw_i,
    input  logic       wr_regwr_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    always_comb begin
        fwd_a_o = fwd_select(ex_rs_i, mem_rw_i, mem_regwr_i, mem_memtoreg_i,
                             wr_rw_i, wr_regwr_i);
        fwd_b_o = fwd_select(ex_rt_i, mem_rw_i, mem_regwr_i, mem_memtoreg_i,
                             wr_rw_i, wr_regwr_i);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/freeze sequencing for the 5-stage pipeline
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       id_Rs,
    input  logic [4:0]       id_Rt,
    input  logic             id_uses_Rt,
    input  logic [4:0]       ex_Rs,
    input  logic [4:0]       ex_Rt,
    input  logic [4:0]       ex_Rw,
    input  logic             ex_RegWr,
    input  logic             ex_MemtoReg,
    input  logic [4:0]       mem_Rw,
    input  logic             mem_RegWr,
    input  logic             mem_MemtoReg,
    input  logic             mem_MemWr,
    input  logic             mem_Branch,
    input  logic             mem_Zero,
    input  logic [4:0]       wr_Rw,
    input  logic             wr_RegWr,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam int                WAIT_W      = $clog2(MEM_LAT) + 1;
    localparam bit                MULTI_CYCLE = (MEM_LAT > 1);
    localparam int                WAIT_INIT_I = MULTI_CYCLE ? (MEM_LAT - 2) : 0;
    localparam logic [WAIT_W-1:0] WAIT_INIT   = WAIT_INIT_I[WAIT_W-1:0];

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   freeze_cnt_q, freeze_cnt_d;

    logic mem_acc;
    logic freeze;
    logic br;
    logic load_use;
    logic lu_match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        else
            return v;
    endfunction

    fwd_unit u_fwd (
        .ex_rs_i        (ex_Rs),
        .ex_rt_i        (ex_Rt),
        .mem_rw_i       (mem_Rw),
        .mem_regwr_i    (mem_RegWr),
        .mem_memtoreg_i (mem_MemtoReg),
        .wr_rw_i        (wr_Rw),
        .wr_regwr_i     (wr_RegWr),
        .fwd_a_o        (fwdA),
        .fwd_b_o        (fwdB)
    );

    assign mem_acc  = mem_MemWr | mem_MemtoReg;
    assign lu_match = (ex_Rw == id_Rs) | (id_uses_Rt & (ex_Rw == id_Rt));

    // Freeze sequencing; the release cycle lets the access complete in MEM.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_acc && MULTI_CYCLE) begin
                    freeze     = 1'b1;
                    state_d    = MWAIT;
                    wait_cnt_d = WAIT_INIT;
                end
            end
            MWAIT: begin
                if (wait_cnt_q != '0) begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (Reset)
            freeze = 1'b0;
    end

    // Hazards are masked while frozen or held in reset; branch beats load-use.
    always_comb begin
        br       = mem_Branch & mem_Zero & ~freeze & ~Reset;
        load_use = ex_MemtoReg & ex_RegWr & (ex_Rw != 5'd0) & lu_match
                   & ~br & ~freeze & ~Reset;

        pc_en       = 1'b1;
        pc_sel      = 1'b0;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (br) begin
            pc_sel      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end

        stall_cnt_d  = sat_inc(stall_cnt_q, load_use);
        flush_cnt_d  = sat_inc(flush_cnt_q, br);
        freeze_cnt_d = sat_inc(freeze_cnt_q, freeze);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;

endmodule
